// File: rtl/mixer_ctrl_pkg.sv
// Shared types and helpers for the mixer gain ramp controller.
// Holds the ramp FSM state type, the unity-gain constant and slot index sizing.
package mixer_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } ramp_state_t;

  // Unity gain in the fixed-point format with q_bits fractional bits.
  function automatic int unsigned unity_gain(input int unsigned q_bits);
    return 32'd1 << q_bits;
  endfunction

  // Index width covering nr_ch channel slots plus the output slot.
  function automatic int unsigned slot_width(input int unsigned nr_ch);
    return (nr_ch < 1) ? 1 : $clog2(nr_ch + 1);
  endfunction

endpackage

// File: rtl/gain_ramp_step.sv
// Combinational single step of a live gain toward its target.
// Works one bit wider than the gain so neither direction can wrap past the target.
module gain_ramp_step #(
  parameter int GAIN_WIDTH_P = 16
) (
  input  logic [GAIN_WIDTH_P-1:0] live,
  input  logic [GAIN_WIDTH_P-1:0] tgt,
  input  logic [GAIN_WIDTH_P-1:0] step,
  output logic [GAIN_WIDTH_P-1:0] next_live
);

  logic [GAIN_WIDTH_P:0] up_sum;
  logic [GAIN_WIDTH_P:0] dn_diff;

  always_comb begin
    up_sum    = {1'b0, live} + {1'b0, step};
    dn_diff   = {1'b0, live} - {1'b0, step};
    next_live = live;
    if (step == '0) begin
      next_live = tgt;
    end else if (live < tgt) begin
      next_live = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[GAIN_WIDTH_P-1:0];
    end else if (live > tgt) begin
      // Top bit of dn_diff flags a borrow, i.e. the step overshot below zero.
      next_live = (dn_diff[GAIN_WIDTH_P] || (dn_diff <= {1'b0, tgt})) ? tgt
                                                                       : dn_diff[GAIN_WIDTH_P-1:0];
    end
  end

endmodule

// File: rtl/mixer_gain_ramp_ctrl.sv
// Mixer gain controller: stores targets and ramps live gains toward them once per divided tick.
// Optional MIXER_GAIN_MUTE_EN adds a per-slot mute that forces the effective target to zero.
module mixer_gain_ramp_ctrl
  import mixer_ctrl_pkg::*;
#(
  parameter int NR_OF_CHANNELS_P = 4,
  parameter int GAIN_WIDTH_P     = 16,
  parameter int Q_BITS_P         = 8,
  parameter int DIV_WIDTH_P      = 8,
  localparam int SLOT_W          = slot_width(NR_OF_CHANNELS_P)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         sample_tick,
  // Config write handshake: a write transfers on a cycle where cfg_wr_valid && cfg_wr_ready.
  input  logic                                         cfg_wr_valid,
  output logic                                         cfg_wr_ready,
  input  logic [SLOT_W-1:0]                            cfg_wr_slot,
  input  logic [GAIN_WIDTH_P-1:0]                      cfg_wr_gain,
  input  logic [GAIN_WIDTH_P-1:0]                      cfg_ramp_step,
  input  logic [DIV_WIDTH_P-1:0]                       cfg_ramp_div,
`ifdef MIXER_GAIN_MUTE_EN
  input  logic [NR_OF_CHANNELS_P:0]                    cfg_mute,
`endif
  output logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] cr_channel_gain,
  output logic [GAIN_WIDTH_P-1:0]                      cr_output_gain,
  output logic                                         ramp_busy,
  output logic                                         ramp_done,
  output ramp_state_t                                  ramp_state
);

  localparam int NR_SLOTS = NR_OF_CHANNELS_P + 1;
  localparam logic [GAIN_WIDTH_P-1:0] UNITY = GAIN_WIDTH_P'(unity_gain(Q_BITS_P));
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NR_OF_CHANNELS_P);

  logic [GAIN_WIDTH_P-1:0] tgt_q   [NR_SLOTS];
  logic [GAIN_WIDTH_P-1:0] live_q  [NR_SLOTS];
  logic [GAIN_WIDTH_P-1:0] eff_tgt [NR_SLOTS];

  ramp_state_t             state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [DIV_WIDTH_P-1:0]  div_cnt_q;
  logic                    pending_q;
  logic                    clear_pending;
  logic                    div_hit;
  logic                    wr_fire;
  logic                    busy_q, busy_d;
  logic                    done_q;
  logic [GAIN_WIDTH_P-1:0] step_next;

  always_comb begin
    for (int i = 0; i < NR_SLOTS; i++) begin
`ifdef MIXER_GAIN_MUTE_EN
      eff_tgt[i] = cfg_mute[i] ? '0 : tgt_q[i];
`else
      eff_tgt[i] = tgt_q[i];
`endif
    end
  end

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NR_SLOTS; i++) begin
      if (live_q[i] != eff_tgt[i]) busy_d = 1'b1;
    end
  end

  assign cfg_wr_ready = (state_q == IDLE);
  assign wr_fire      = cfg_wr_valid && cfg_wr_ready;
  assign div_hit      = sample_tick && (div_cnt_q == cfg_ramp_div);

  gain_ramp_step #(
    .GAIN_WIDTH_P(GAIN_WIDTH_P)
  ) u_step (
    .live      (live_q[slot_q]),
    .tgt       (eff_tgt[slot_q]),
    .step      (cfg_ramp_step),
    .next_live (step_next)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    clear_pending = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d       = SCAN;
          slot_d        = '0;
          clear_pending = 1'b1;
        end
      end
      SCAN: begin
        if (slot_q == LAST_SLOT) begin
          state_d = IDLE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      div_cnt_q <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NR_SLOTS; i++) begin
        tgt_q[i]  <= UNITY;
        live_q[i] <= UNITY;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      if (sample_tick) div_cnt_q <= div_hit ? '0 : div_cnt_q + 1'b1;
      // A fresh divider hit outranks the clear so no update request is lost.
      if (div_hit) pending_q <= 1'b1;
      else if (clear_pending) pending_q <= 1'b0;
      if (wr_fire && (cfg_wr_slot <= LAST_SLOT)) tgt_q[cfg_wr_slot] <= cfg_wr_gain;
      if (state_q == SCAN) live_q[slot_q] <= step_next;
      busy_q <= busy_d;
      done_q <= busy_q && !busy_d;
    end
  end

  for (genvar g = 0; g < NR_OF_CHANNELS_P; g++) begin : g_ch_out
    assign cr_channel_gain[g] = live_q[g];
  end
  assign cr_output_gain = live_q[NR_OF_CHANNELS_P];
  assign ramp_busy      = busy_q;
  assign ramp_done      = done_q;
  assign ramp_state     = state_q;

endmodule

// File: tb/tb_mixer_gain_ramp_ctrl.sv
// Directed bench for mixer_gain_ramp_ctrl with hand-computed gain sequences.
// Build with MIXER_GAIN_MUTE_EN defined to also exercise the mute path.
module tb_mixer_gain_ramp_ctrl;
  import mixer_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int G  = 16;
  localparam int Q  = 8;
  localparam int D  = 8;
  localparam int SW = slot_width(N);

  logic                clk;
  logic                rst;
  logic                sample_tick;
  logic                cfg_wr_valid;
  logic                cfg_wr_ready;
  logic [SW-1:0]       cfg_wr_slot;
  logic [G-1:0]        cfg_wr_gain;
  logic [G-1:0]        cfg_ramp_step;
  logic [D-1:0]        cfg_ramp_div;
`ifdef MIXER_GAIN_MUTE_EN
  logic [N:0]          cfg_mute;
`endif
  logic [N-1:0][G-1:0] cr_channel_gain;
  logic [G-1:0]        cr_output_gain;
  logic                ramp_busy;
  logic                ramp_done;
  ramp_state_t         ramp_state;

  int checks;
  int errors;
  int done_cnt;
  int scan_starts;
  int ready_low;
  logic prev_ready;

  mixer_gain_ramp_ctrl #(
    .NR_OF_CHANNELS_P(N),
    .GAIN_WIDTH_P    (G),
    .Q_BITS_P        (Q),
    .DIV_WIDTH_P     (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_tick    (sample_tick),
    .cfg_wr_valid   (cfg_wr_valid),
    .cfg_wr_ready   (cfg_wr_ready),
    .cfg_wr_slot    (cfg_wr_slot),
    .cfg_wr_gain    (cfg_wr_gain),
    .cfg_ramp_step  (cfg_ramp_step),
    .cfg_ramp_div   (cfg_ramp_div),
`ifdef MIXER_GAIN_MUTE_EN
    .cfg_mute       (cfg_mute),
`endif
    .cr_channel_gain(cr_channel_gain),
    .cr_output_gain (cr_output_gain),
    .ramp_busy      (ramp_busy),
    .ramp_done      (ramp_done),
    .ramp_state     (ramp_state)
  );

  // Clock and time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "time limit");
  end

  // Monitor: ramp_done pulses, scan entries and cycles with ready low
  initial prev_ready = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      if (ramp_done) done_cnt++;
      if (!cfg_wr_ready) ready_low++;
      if (prev_ready && !cfg_wr_ready) scan_starts++;
    end
    prev_ready = cfg_wr_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_gains(input logic [G-1:0] e0, input logic [G-1:0] e1,
                             input logic [G-1:0] e2, input logic [G-1:0] e3,
                             input logic [G-1:0] eo);
    check("ch0", 32'(cr_channel_gain[0]), 32'(e0));
    check("ch1", 32'(cr_channel_gain[1]), 32'(e1));
    check("ch2", 32'(cr_channel_gain[2]), 32'(e2));
    check("ch3", 32'(cr_channel_gain[3]), 32'(e3));
    check("out", 32'(cr_output_gain), 32'(eo));
  endtask

  // Driver: one tick pulse, then enough cycles for the whole scan to finish
  task automatic tick_scan();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_gain(input logic [SW-1:0] slot, input logic [G-1:0] gain);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cfg_wr_valid = 1'b1;
    cfg_wr_slot  = slot;
    cfg_wr_gain  = gain;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cfg_wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 cfg_wr_valid = 1'b0;
    check("wr_accept", 32'(ok), 32'd1);
  endtask

  logic [G-1:0] exp_up [4];
  logic [G-1:0] exp_dn [3];

  initial begin
    checks = 0; errors = 0; done_cnt = 0; scan_starts = 0; ready_low = 0;
    exp_up[0] = 16'd320; exp_up[1] = 16'd384; exp_up[2] = 16'd448; exp_up[3] = 16'd512;
    exp_dn[0] = 16'd156; exp_dn[1] = 16'd56;  exp_dn[2] = 16'd0;
    rst = 1'b1; sample_tick = 1'b0; cfg_wr_valid = 1'b0;
    cfg_wr_slot = '0; cfg_wr_gain = '0; cfg_ramp_step = 16'd64; cfg_ramp_div = '0;
`ifdef MIXER_GAIN_MUTE_EN
    cfg_mute = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_gains(256, 256, 256, 256, 256);
    check("rst_busy", 32'(ramp_busy), 0);
    check("rst_done", 32'(ramp_done), 0);
    check("rst_ready", 32'(cfg_wr_ready), 1);
    check("rst_state", 32'(ramp_state), 32'(IDLE));

    // 100 idle ticks leave unity everywhere
    for (int i = 0; i < 100; i++) tick_scan();
    check_gains(256, 256, 256, 256, 256);
    check("idle_busy", 32'(ramp_busy), 0);
    check("idle_done_cnt", 32'(done_cnt), 0);

    // Ramp up slot 0 to 512 in steps of 64
    write_gain(0, 16'd512);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("up_busy_pre", 32'(ramp_busy), 1);
    check("up_ch0_pre", 32'(cr_channel_gain[0]), 256);
    for (int k = 0; k < 4; k++) begin
      tick_scan();
      check("up_ch0", 32'(cr_channel_gain[0]), 32'(exp_up[k]));
      check("up_busy", 32'(ramp_busy), (k < 3) ? 32'd1 : 32'd0);
      check("up_done_cnt", 32'(done_cnt), (k < 3) ? 32'd0 : 32'd1);
    end

    // Output ramps down by 100 and clamps at 0
    cfg_ramp_step = 16'd100;
    write_gain(3'(N), 16'd0);
    for (int k = 0; k < 3; k++) begin
      tick_scan();
      check("dn_out", 32'(cr_output_gain), 32'(exp_dn[k]));
    end
    check_gains(512, 256, 256, 256, 0);
    check("dn_done_cnt", 32'(done_cnt), 2);

    // Step 0 snaps to target
    cfg_ramp_step = 16'd0;
    write_gain(2, 16'd1000);
    tick_scan();
    check("snap_ch2", 32'(cr_channel_gain[2]), 1000);
    check("snap_done_cnt", 32'(done_cnt), 3);

    // Second tick lands inside a scan and is served back-to-back
    cfg_ramp_step = 16'd64;
    write_gain(3, 16'd512);
    scan_starts = 0;
    ready_low   = 0;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("pend_ch3", 32'(cr_channel_gain[3]), 384);
    check("pend_scans", 32'(scan_starts), 2);
    check("pend_ready_low", 32'(ready_low), 10);
    check("pend_busy", 32'(ramp_busy), 1);

    // Divider 2: only every third tick updates
    cfg_ramp_div = 8'd2;
    tick_scan();
    tick_scan();
    check("div_ch3_hold", 32'(cr_channel_gain[3]), 384);
    tick_scan();
    check("div_ch3_step", 32'(cr_channel_gain[3]), 448);
    cfg_ramp_div = 8'd0;
    tick_scan();
    check("div_ch3_end", 32'(cr_channel_gain[3]), 512);
    check("div_done_cnt", 32'(done_cnt), 4);
    check("div_busy", 32'(ramp_busy), 0);

    // Out-of-range slot is accepted and ignored
    write_gain(3'd7, 16'd0);
    tick_scan();
    check_gains(512, 256, 1000, 512, 0);
    check("oor_busy", 32'(ramp_busy), 0);
    check("oor_done_cnt", 32'(done_cnt), 4);

`ifdef MIXER_GAIN_MUTE_EN
    // Mute ramps slot 1 to 0, unmute returns to the stored 256
    cfg_ramp_step = 16'd128;
    cfg_mute = 5'b00010;
    tick_scan();
    check("mute_ch1_a", 32'(cr_channel_gain[1]), 128);
    check("mute_busy", 32'(ramp_busy), 1);
    tick_scan();
    check("mute_ch1_b", 32'(cr_channel_gain[1]), 0);
    check("mute_done_cnt", 32'(done_cnt), 5);
    cfg_mute = '0;
    tick_scan();
    check("unmute_ch1_a", 32'(cr_channel_gain[1]), 128);
    tick_scan();
    check("unmute_ch1_b", 32'(cr_channel_gain[1]), 256);
    check("unmute_done_cnt", 32'(done_cnt), 6);
    check("unmute_busy", 32'(ramp_busy), 0);
    check_gains(512, 256, 1000, 512, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
